// File: rtl/logic_unit_pkg.sv
// Shared types and the reference bitwise op for the logic unit family.
// logic_apply is also used by the single-cycle ALU.
package logic_unit_pkg;

   localparam int LU_MAX_W = 64;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } logic_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } lu_state_e;

   // Callers zero-extend operands and keep only their own low bits.
   function automatic logic [LU_MAX_W-1:0] logic_apply(
      input logic_op_e             op,
      input logic [LU_MAX_W-1:0]   a,
      input logic [LU_MAX_W-1:0]   b
   );
      logic [LU_MAX_W-1:0] r;
      r = '0;
      unique case (op)
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_NOR: r = ~(a | b);
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-wide bitwise op unit.
// Shared by every slice position through the operand mux in the top.
module logic_slice
   import logic_unit_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [1:0]       op,
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   output logic [SLICE-1:0] y
);

   always_comb begin
      y = '0;
      unique case (logic_op_e'(op))
         OP_AND: y = a & b;
         OP_OR:  y = a | b;
         OP_XOR: y = a ^ b;
         OP_NOR: y = ~(a | b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/bitwise_logic_unit_seq.sv
// Multi-cycle bitwise logic unit: SLICE bits per cycle, LSB slice first,
// valid/ready handshake on both sides, one transaction in flight.
module bitwise_logic_unit_seq
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   lu_state_e        state, state_d;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic [1:0]       op_q;
   logic             zero_q;
   logic [SLICE-1:0] a_sl, b_sl, y_sl;
   logic             last;

   assign a_sl = a_q[SLICE*int'(cnt) +: SLICE];
   assign b_sl = b_q[SLICE*int'(cnt) +: SLICE];
   assign last = (cnt == CW'(N-1));

   logic_slice #(.SLICE(SLICE)) u_slice (
      .op (op_q),
      .a  (a_sl),
      .b  (b_sl),
      .y  (y_sl)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: if (last) state_d = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         res_q  <= '0;
         cnt    <= '0;
         zero_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               a_q    <= input1;
               b_q    <= input2;
               op_q   <= op;
               res_q  <= '0;
               cnt    <= '0;
               zero_q <= 1'b1;
            end
            RUN: begin
               res_q[SLICE*int'(cnt) +: SLICE] <= y_sl;
               zero_q <= zero_q & (y_sl == '0);
               cnt    <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign result = res_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_bitwise_logic_unit_seq.sv
// Bench for bitwise_logic_unit_seq in three configurations:
// u0 32/8, u1 32/32, u2 16/4.
module tb_bitwise_logic_unit_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv   [3];
   logic        ordy [3];
   logic [1:0]  opv  [3];
   logic [31:0] av   [3];
   logic [31:0] bv   [3];
   logic        ir   [3];
   logic        ov   [3];
   logic        zv   [3];
   logic [31:0] r0, r1;
   logic [15:0] r2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bitwise_logic_unit_seq #(.WIDTH(32), .SLICE(8)) u0 (
      .clk(clk), .reset_n(rst_n),
      .in_valid(iv[0]), .in_ready(ir[0]), .op(opv[0]),
      .input1(av[0]), .input2(bv[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]),
      .result(r0), .zero(zv[0])
   );

   bitwise_logic_unit_seq #(.WIDTH(32), .SLICE(32)) u1 (
      .clk(clk), .reset_n(rst_n),
      .in_valid(iv[1]), .in_ready(ir[1]), .op(opv[1]),
      .input1(av[1]), .input2(bv[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]),
      .result(r1), .zero(zv[1])
   );

   bitwise_logic_unit_seq #(.WIDTH(16), .SLICE(4)) u2 (
      .clk(clk), .reset_n(rst_n),
      .in_valid(iv[2]), .in_ready(ir[2]), .op(opv[2]),
      .input1(av[2][15:0]), .input2(bv[2][15:0]),
      .out_valid(ov[2]), .out_ready(ordy[2]),
      .result(r2), .zero(zv[2])
   );

   function automatic logic [31:0] res_of(input int u);
      if (u == 0) return r0;
      if (u == 1) return r1;
      return {16'h0, r2};
   endfunction

   function automatic int width_of(input int u);
      return (u == 2) ? 16 : 32;
   endfunction

   function automatic int lat_of(input int u);
      return (u == 1) ? 1 : 4;
   endfunction

   // Truth table per op, indexed by {a_bit, b_bit}.
   function automatic logic [31:0] model(input logic [1:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y,
                                         input int w);
      logic [3:0]  tt;
      logic [31:0] r;
      case (o)
         2'd0: tt = 4'b1000;
         2'd1: tt = 4'b1110;
         2'd2: tt = 4'b0110;
         default: tt = 4'b0001;
      endcase
      r = '0;
      for (int i = 0; i < w; i++) r[i] = tt[{x[i], y[i]}];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_ov(input int u, output int lat);
      lat = 0;
      while (!ov[u] && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Called #1 after a rising edge with the unit idle; leaves it idle.
   task automatic txn(input int u, input logic [1:0] o,
                      input logic [31:0] x, input logic [31:0] y,
                      output logic [31:0] res, output logic zr,
                      output int lat);
      iv[u]  = 1'b1;
      opv[u] = o;
      av[u]  = x;
      bv[u]  = y;
      @(posedge clk); #1;
      iv[u] = 1'b0;
      wait_ov(u, lat);
      res = res_of(u);
      zr  = zv[u];
      ordy[u] = 1'b1;
      @(posedge clk); #1;
      ordy[u] = 1'b0;
   endtask

   typedef struct {
      int          u;
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
   } vec_t;

   vec_t        tbl [7];
   logic [31:0] res, exp, ca, cb;
   logic [1:0]  co;
   logic        zr;
   int          lat;

   initial begin
      tbl[0] = '{0, 2'd3, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      tbl[1] = '{0, 2'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1};
      tbl[2] = '{0, 2'd2, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b0};
      tbl[3] = '{0, 2'd1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tbl[4] = '{1, 2'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, 1'b0};
      tbl[5] = '{1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
      tbl[6] = '{2, 2'd3, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_F000, 1'b0};

      for (int u = 0; u < 3; u++) begin
         iv[u] = 1'b0; ordy[u] = 1'b0; opv[u] = '0;
         av[u] = '0;   bv[u] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(ir[0]), 32'd1);
      chk("reset_out_valid", 32'(ov[0]), 32'd0);
      chk("reset_result", r0, 32'd0);
      chk("reset_zero", 32'(zv[0]), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         chk($sformatf("vec%0d_in_ready", i), 32'(ir[tbl[i].u]), 32'd1);
         txn(tbl[i].u, tbl[i].o, tbl[i].a, tbl[i].b, res, zr, lat);
         chk($sformatf("vec%0d_result", i), res, tbl[i].res);
         chk($sformatf("vec%0d_zero", i), 32'(zr), 32'(tbl[i].z));
         chk($sformatf("vec%0d_latency", i), lat, lat_of(tbl[i].u));
      end

      // Backpressure with new operands offered while in DONE.
      iv[0] = 1'b1; opv[0] = 2'd0;
      av[0] = 32'hAAAA_5555; bv[0] = 32'h0F0F_0F0F;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      wait_ov(0, lat);
      chk("bp_latency", lat, 4);
      exp = 32'h0A0A_0505;
      for (int c = 0; c < 10; c++) begin
         iv[0] = 1'b1; opv[0] = 2'($urandom_range(3));
         av[0] = $urandom; bv[0] = $urandom;
         @(posedge clk); #1;
         chk("bp_result_hold", r0, exp);
         chk("bp_in_ready_low", 32'(ir[0]), 32'd0);
         chk("bp_out_valid_high", 32'(ov[0]), 32'd1);
      end
      iv[0] = 1'b0; ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      chk("bp_release_in_ready", 32'(ir[0]), 32'd1);
      chk("bp_release_out_valid", 32'(ov[0]), 32'd0);
      txn(0, 2'd2, 32'hDEAD_BEEF, 32'hFFFF_FFFF, res, zr, lat);
      chk("bp_next_result", res, 32'h2152_4110);

      // Operands churn during RUN; the captured ones must win.
      ca = 32'h0123_4567; cb = 32'h89AB_CDEF; co = 2'd1;
      iv[0] = 1'b1; opv[0] = co; av[0] = ca; bv[0] = cb;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      lat = 0;
      while (!ov[0] && lat < 30) begin
         av[0] = $urandom; bv[0] = $urandom; opv[0] = 2'($urandom_range(3));
         @(posedge clk); #1;
         lat++;
      end
      chk("churn_latency", lat, 4);
      chk("churn_result", r0, 32'h89AB_CDEF);
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;

      // Reset after two slices aborts the transaction.
      iv[0] = 1'b1; opv[0] = 2'd3; av[0] = '0; bv[0] = '0;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(ov[0]), 32'd0);
      chk("abort_result", r0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_in_ready", 32'(ir[0]), 32'd1);
      chk("abort_out_valid_after", 32'(ov[0]), 32'd0);
      txn(0, 2'd1, 32'h8000_0000, 32'h0000_0001, res, zr, lat);
      chk("abort_next_result", res, 32'h8000_0001);
      chk("abort_next_latency", lat, 4);

      // Randomised sweep over all three configurations.
      for (int u = 0; u < 3; u++) begin
         for (int k = 0; k < 20; k++) begin
            co = 2'($urandom_range(3));
            ca = $urandom; cb = $urandom;
            if (k == 0) cb = ca;
            exp = model(co, ca, cb, width_of(u));
            txn(u, co, ca, cb, res, zr, lat);
            chk($sformatf("rnd_u%0d_result", u), res, exp);
            chk($sformatf("rnd_u%0d_zero", u), 32'(zr), 32'(exp == 0));
            chk($sformatf("rnd_u%0d_latency", u), lat, lat_of(u));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
